fifo_block_drain_ctrl: RTL and testbench

- Read-side sequencer for the 1-bit-in / 16-bit-out acquisition FIFO (1024 deep); lives in the FIFO read-clock domain.
- Waits until a full block of 16-bit words is buffered, then announces the block to the host pipe and drains it word by word through a 2-entry prefetch buffer.
- Hides the FIFO's 1-cycle read latency; flags host protocol errors.

---
 rtl/fifo_block_drain_ctrl.sv | 97 +++++++++
 tb/tb_fifo_block_drain_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_block_drain_ctrl.sv
// fifo_block_drain_ctrl: waits for a full block in the read-side FIFO, then drains it through a 2-entry prefetch buffer.
// Define FIFO_DRAIN_HDR_EN to prefix every block with a {4'hA, blk_seq} header word.
module fifo_block_drain_ctrl #(
    parameter int BLOCK_WORDS = 32,
    parameter int LEVEL_W     = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               abort,
    input  logic [15:0]        fifo_dout,
    input  logic               fifo_empty,
    input  logic [LEVEL_W-1:0] fifo_rd_count,
    output logic               fifo_rd_en,
    output logic               pipe_ready,
    output logic [15:0]        pipe_data,
    output logic               pipe_valid,
    input  logic               pipe_read,
    output logic               blk_done,
    output logic               underrun,
    output logic [11:0]        blk_seq
);
    typedef enum logic [1:0] {IDLE, WAIT_LVL, XFER, DONE} state_t;
    localparam logic [LEVEL_W-1:0] FETCH_LEN = LEVEL_W'(BLOCK_WORDS);
`ifdef FIFO_DRAIN_HDR_EN
    localparam logic [LEVEL_W-1:0] BLK_LEN = LEVEL_W'(BLOCK_WORDS + 1);
    localparam logic               HDR_EN  = 1'b1;
`else
    localparam logic [LEVEL_W-1:0] BLK_LEN = LEVEL_W'(BLOCK_WORDS);
    localparam logic               HDR_EN  = 1'b0;
`endif
    state_t             state, state_nxt;
    logic               lvl_ok, in_flight, pop, load_hdr;
    logic [1:0]         occ, occ_nxt, kept;
    logic [15:0]        buf0, buf1, buf0_nxt, buf1_nxt;
    logic [LEVEL_W-1:0] fetched, delivered;
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     state_nxt = en ? WAIT_LVL : IDLE;
            WAIT_LVL: state_nxt = !en ? IDLE : (lvl_ok ? XFER : WAIT_LVL);
            XFER:     state_nxt = (delivered == BLK_LEN) ? DONE : XFER;
            DONE:     state_nxt = WAIT_LVL;
        endcase
        if (abort) state_nxt = en ? WAIT_LVL : IDLE;
    end
    // A same-cycle pop frees a slot, so the fetch budget counts it to sustain 1 word/cycle.
    always_comb begin
        pop        = pipe_read && (occ != 2'd0);
        kept       = occ - {1'b0, pop};
        load_hdr   = HDR_EN && (state == WAIT_LVL) && (state_nxt == XFER);
        fifo_rd_en = (state == XFER) && !abort && (fetched < FETCH_LEN) && !fifo_empty
                     && (({1'b0, occ} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop}));
        buf0_nxt   = (in_flight && kept == 2'd0) ? fifo_dout : ((pop && occ == 2'd2) ? buf1 : buf0);
        buf1_nxt   = (in_flight && kept != 2'd0) ? fifo_dout : buf1;
        occ_nxt    = kept + {1'b0, in_flight};
    end
    assign pipe_valid = occ != 2'd0;
    assign pipe_data  = buf0;
    assign pipe_ready = state == XFER;
    assign blk_done   = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lvl_ok    <= 1'b0;
            in_flight <= 1'b0;
            occ       <= 2'd0;
            buf0      <= 16'h0000;
            buf1      <= 16'h0000;
            fetched   <= '0;
            delivered <= '0;
            underrun  <= 1'b0;
            blk_seq   <= 12'd0;
        end else begin
            state    <= state_nxt;
            lvl_ok   <= fifo_rd_count >= FETCH_LEN;
            blk_seq  <= blk_seq + 12'(state == DONE);
            underrun <= !abort && (underrun || (pipe_read && occ == 2'd0));
            if (abort || state == DONE) begin
                in_flight <= 1'b0;
                occ       <= 2'd0;
                fetched   <= '0;
                delivered <= '0;
            end else if (load_hdr) begin
                buf0 <= {4'hA, blk_seq};
                occ  <= 2'd1;
            end else begin
                in_flight <= fifo_rd_en;
                occ       <= occ_nxt;
                buf0      <= buf0_nxt;
                buf1      <= buf1_nxt;
                fetched   <= fetched + LEVEL_W'(fifo_rd_en);
                delivered <= delivered + LEVEL_W'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fifo_block_drain_ctrl.sv
// tb_fifo_block_drain_ctrl: scoreboard bench; FIFO word order plus block/header rules predict every delivered word.
module tb_fifo_block_drain_ctrl;
    localparam int BW = 32;
    localparam int LW = 11;
`ifdef FIFO_DRAIN_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    localparam int BLK_LEN = BW + HDR;
    localparam int SPAN    = BLK_LEN - 1 + HDR;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, abort = 1'b0, pipe_read = 1'b0;
    logic [15:0] fifo_dout;
    logic fifo_empty, fifo_rd_en, pipe_ready, pipe_valid, blk_done, underrun;
    logic [LW-1:0] fifo_rd_count;
    logic [15:0] pipe_data;
    logic [11:0] blk_seq;

    int tests = 0, fails = 0;
    logic [15:0] mem [1024];
    int wp = 0, rp = 0;
    logic [15:0] serial = 16'h0001;
    logic ovr_en = 1'b0;
    int ovr = 0;
    logic [15:0] exp_q [$];
    int host_mode = 0;
    logic probe_done = 1'b0;
    logic mon_en = 1'b0, stream_chk = 1'b0, model_ur = 1'b0;
    int widx = 0, model_seq = 0, rd_blk = 0, outst = 0, first_t = 0, last_t = 0, cyc = 0, ndone = 0;

    assign fifo_empty    = (wp == rp);
    assign fifo_rd_count = LW'(ovr_en ? ovr : wp - rp);

    always #5 clk = ~clk;

    fifo_block_drain_ctrl #(.BLOCK_WORDS(BW), .LEVEL_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .abort(abort),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_count(fifo_rd_count),
        .fifo_rd_en(fifo_rd_en), .pipe_ready(pipe_ready), .pipe_data(pipe_data),
        .pipe_valid(pipe_valid), .pipe_read(pipe_read), .blk_done(blk_done),
        .underrun(underrun), .blk_seq(blk_seq)
    );

    // FIFO with 1-cycle read latency
    always @(posedge clk) begin
        if (rst_n && fifo_rd_en && wp != rp) begin
            fifo_dout <= mem[rp % 1024];
            rp <= rp + 1;
        end
    end

    task automatic check(string name, int got, int expv);
        tests++;
        if (got != expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(int n);
        for (int i = 0; i < n; i++) begin
            mem[wp % 1024] = serial;
            exp_q.push_back(serial);
            serial = serial + 16'd1;
            wp = wp + 1;
        end
    endtask

    task automatic check_reset(string name);
        check({name, "_rd_en"}, fifo_rd_en, 0);
        check({name, "_ready"}, pipe_ready, 0);
        check({name, "_valid"}, pipe_valid, 0);
        check({name, "_data"}, pipe_data, 0);
        check({name, "_done"}, blk_done, 0);
        check({name, "_underrun"}, underrun, 0);
        check({name, "_seq"}, blk_seq, 0);
    endtask

    task automatic idle_check(string name);
        int hits;
        hits = 0;
        repeat (100) begin
            @(negedge clk);
            if (fifo_rd_en || pipe_ready) hits++;
        end
        check(name, hits, 0);
    endtask

    task automatic wait_ready(string name);
        for (int i = 0; i < 300 && !pipe_ready; i++) tick();
        check(name, pipe_ready, 1);
    endtask

    task automatic wait_done(string name);
        int n0;
        n0 = ndone;
        for (int i = 0; i < 3000 && ndone == n0; i++) tick();
        check(name, int'(ndone != n0), 1);
    endtask

    // Host: 0 idle, 1 read whenever valid, 2 random 1-in-3, 3 single read on first pipe_ready cycle
    initial forever begin
        @(posedge clk);
        #1;
        pipe_read = (host_mode == 3) ? (pipe_ready && !probe_done)
                  : (pipe_valid && (host_mode == 1 || (host_mode == 2 && $urandom_range(2) == 0)));
        if (host_mode == 3 && pipe_ready) probe_done = 1'b1;
    end

    // Monitor: pops expectations on every accepted word and checks block bookkeeping
    always @(negedge clk) begin
        cyc++;
        if (rst_n && mon_en) begin
            check("underrun_flag", underrun, model_ur);
            if (fifo_rd_en) begin
                check("rd_while_empty", fifo_empty, 0);
                rd_blk++;
                outst++;
            end
            if (pipe_read && !pipe_valid) model_ur = 1'b1;
            if (pipe_read && pipe_valid) begin
                if (HDR != 0 && widx == 0) check("header", pipe_data, {4'hA, 12'(model_seq)});
                else if (exp_q.size() == 0) check("exp_underflow", 1, 0);
                else begin
                    check("data", pipe_data, exp_q.pop_front());
                    outst--;
                end
                if (widx == 0) first_t = cyc;
                last_t = cyc;
                widx++;
            end
            check("occupancy", int'(outst <= 2), 1);
            if (blk_done) begin
                check("blk_seq", blk_seq, model_seq);
                check("blk_words", widx, BLK_LEN);
                check("blk_reads", rd_blk, BW);
                if (stream_chk) check("throughput", last_t - first_t, SPAN);
                model_seq = (model_seq + 1) % 4096;
                widx = 0;
                rd_blk = 0;
                ndone++;
            end
            if (abort) begin
                model_ur = 1'b0;
                widx = 0;
                rd_blk = 0;
                outst = 0;
                while (exp_q.size() > wp - rp) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int hits, pushed;
        repeat (3) @(posedge clk);
        #1;
        check_reset("init");
        push_words(40);
        rst_n = 1'b1;
        idle_check("idle_after_reset");
        // threshold, then full block streaming
        mon_en = 1'b1;
        ovr_en = 1'b1;
        ovr = 31;
        en = 1'b1;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            hits += int'(pipe_ready);
        end
        check("below_threshold", hits, 0);
        tick();
        ovr = 32;
        host_mode = 1;
        stream_chk = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("threshold_ready", pipe_ready, 1);
        ovr_en = 1'b0;
        wait_done("stream_done");
        tick();
        check("blk_seq_first", blk_seq, 1);
        // host stalls with a starved FIFO behind an optimistic level
        stream_chk = 1'b0;
        host_mode = 2;
        push_words(8);
        ovr = 100;
        ovr_en = 1'b1;
        wait_ready("stall_start");
        en = 1'b0;
        pushed = 0;
        for (int i = 0; i < 3000 && ndone == 1; i++) begin
            tick();
            if (pushed < 24 && $urandom_range(3) == 0) begin
                push_words(1);
                pushed++;
            end
        end
        check("stall_done", ndone, 2);
        ovr_en = 1'b0;
        // underrun probe on the first XFER cycle, then abort mid-block
        host_mode = 3;
        push_words(50);
        repeat (3) tick();
        en = 1'b1;
        for (int i = 0; i < 300 && !probe_done; i++) tick();
        check("probe", probe_done, 1);
        host_mode = 1;
        for (int i = 0; i < 300 && widx < 10 + HDR; i++) tick();
        check("abort_point", int'(widx >= 10 + HDR), 1);
        host_mode = 0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", pipe_valid, 0);
        check("abort_underrun", underrun, 0);
        check("abort_ready", pipe_ready, 0);
        check("abort_seq", blk_seq, 2);
        tick();
        host_mode = 1;
        stream_chk = 1'b1;
        wait_done("after_abort_done");
        // asynchronous reset in the middle of a transfer
        stream_chk = 1'b0;
        push_words(40);
        wait_ready("reset_block_start");
        repeat (5) tick();
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        en = 1'b0;
        host_mode = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        idle_check("idle_after_mid_reset");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
        $fatal(1);
    end
endmodule
